pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 Parameter N, default 10, width of counter, period, duty and step fields.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  run request; 0 forces IDLE.
REQ-005 cfg_valid  input  1  config word offered.
REQ-006 cfg_ready  output  1  shadow register empty, config can be accepted.
REQ-007 cfg_period  input  N  terminal count; period = cfg_period+1 cycles.
REQ-008 cfg_duty  input  N  target high-cycles per period.
REQ-009 cfg_step  input  N  duty change per period during ramp; 0 = jump immediately.
REQ-010 count_out  output  N  current period count.
REQ-011 pwm_out  output  1  registered PWM output.
REQ-012 period_done  output  1  one-cycle pulse on the cycle count_out equals active period and wraps.
REQ-013 busy  output  1  high while state is RAMP.

Function
REQ-014 FSM states IDLE, RUN, RAMP; enable=0 from any state -> IDLE next cycle.
REQ-015 IDLE: count_out held 0, duty_cur cleared to 0, pwm_out 0, period_done 0.
REQ-016 IDLE with enable=1 -> RAMP if duty_tgt != 0, else RUN.
REQ-017 RUN/RAMP: count_out increments each cycle; at count_out == period_act it wraps to 0 and period_done=1 that cycle.
REQ-018 period_act = 0: count_out stays 0, period_done high every running cycle.
REQ-019 pwm_out at cycle t+1 = (count_out < duty_cur) at cycle t; duty_cur > period_act gives 100% high, duty_cur = 0 gives constant low.
REQ-020 Handshake: transfer when cfg_valid & cfg_ready; fields captured into shadow, pending set; cfg_ready = ~pending (combinational).
REQ-021 Shadow loads into period_act/duty_tgt/step_act at the next period boundary (period_done cycle), or on the cycle after acceptance when in IDLE; pending clears the same edge; cfg_ready high the next cycle.
REQ-022 A transfer accepted in the same cycle as a boundary waits for the following boundary.
REQ-023 Ramp update at each boundary in RUN/RAMP uses the values loaded at that same boundary: if step_act = 0 or |duty_tgt - duty_cur| <= step_act then duty_cur <= duty_tgt, else duty_cur moves toward duty_tgt by step_act.
REQ-024 RUN -> RAMP when duty_cur != duty_tgt after a boundary load; RAMP -> RUN on the boundary where duty_cur reaches duty_tgt.
REQ-025 All subtractions/comparisons unsigned on N bits; no wrap of duty_cur past 0 or past duty_tgt.

Reset
REQ-026 Reset values: count_out 0, pwm_out 0, period_done 0, busy 0, state IDLE, period_act 511, duty_tgt 0, duty_cur 0, step_act 0, pending 0 (cfg_ready 1).
REQ-027 Reset asserted mid-ramp or mid-period discards pending shadow and returns all state to REQ-026 values on the next edge.

Structure
REQ-028 Shared package pwm_pkg holds state enum, PWM_W = 10, DEFAULT_PERIOD = 511.
REQ-029 Sub-module pwm_period_counter: loadable-terminal counter with clear, enable and wrap pulse; controller FSM, shadow and ramp logic in pwm_ramp_ctrl.

Verification
REQ-030 Reset, enable=1, no config -> count 0..511 wraps, period_done every 512 cycles, pwm_out constant 0.
REQ-031 In IDLE send period=9, duty=4, step=0; enable -> pwm_out high 4 of every 10 cycles, period_done every 10 cycles, busy high one period then 0.
REQ-032 Running period=9, duty=0; send duty=8, step=3 -> duty_cur 3, 6, 8 on successive boundaries, busy high until 8 reached, cfg_ready low from acceptance to first boundary.
REQ-033 cfg_valid held continuously with two words -> second accepted only after first loads; each loads at its own boundary; cfg_valid on a boundary cycle waits one period.
REQ-034 period=0 with duty=1 -> pwm_out constant 1, period_done every cycle; duty=0 -> pwm_out constant 0.
REQ-035 Reset or enable=0 mid-ramp -> IDLE, outputs 0 next edge; re-enable restarts ramp from duty_cur 0 (enable) or from reset defaults (reset).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller slice.
//   PWM_W          default width of counter, period, duty and step fields
//   DEFAULT_PERIOD terminal count used out of reset (512-cycle period)
//   pwm_state_e    controller state encoding
package pwm_pkg;

    localparam int PWM_W          = 10;
    localparam int DEFAULT_PERIOD = 511;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RAMP = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Configuration handshake bundle for pwm_ramp_ctrl.
//   cfg_valid   master -> slave  config word offered
//   cfg_ready   slave -> master  shadow register empty
//   cfg_period  master -> slave  terminal count (period = cfg_period + 1)
//   cfg_duty    master -> slave  target high cycles per period
//   cfg_step    master -> slave  duty change per period while ramping (0 = jump)
interface pwm_ramp_ctrl_if
    import pwm_pkg::*;
#(
    parameter int N = PWM_W
);

    logic         cfg_valid;
    logic         cfg_ready;
    logic [N-1:0] cfg_period;
    logic [N-1:0] cfg_duty;
    logic [N-1:0] cfg_step;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        output cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        input  cfg_step,
        output cfg_ready
    );

endinterface

// File: rtl/pwm_period_counter.sv
// Period counter with loadable terminal count.
//   clk, reset  clock and synchronous active-high reset
//   clear_i     force the count to 0 on the next edge (highest priority)
//   en_i        count enable
//   term_i      terminal count; the count wraps to 0 after reaching it
//   count_o     current count
//   wrap_o      high on the enabled cycle where count_o == term_i
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int N = PWM_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [N-1:0] term_i,
    output logic [N-1:0] count_o,
    output logic         wrap_o
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic         wrap;

    assign wrap = en_i & (count_q == term_i);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap ? '0 : count_q + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with shadowed configuration and per-period duty ramping.
//   clk, reset   clock and synchronous active-high reset
//   enable       run request; low forces IDLE on the next edge
//   cfg          configuration handshake (slave side)
//   count_out    current position within the period
//   pwm_out      registered PWM output
//   period_done  one-cycle pulse on the last cycle of each period
//   busy         high while the duty is ramping toward its target
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | stopped; count and duty held at 0, shadow loads at once
// ST_RUN  | duty_cur equals duty_tgt, PWM running
// ST_RAMP | duty_cur stepping toward duty_tgt once per period
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int N = PWM_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    pwm_ramp_ctrl_if.slave        cfg,
    output logic [N-1:0]          count_out,
    output logic                  pwm_out,
    output logic                  period_done,
    output logic                  busy
);

    localparam logic [N-1:0] PERIOD_RST = N'(DEFAULT_PERIOD);

    pwm_state_e   state_q, state_d;
    logic [N-1:0] period_act_q, period_act_d;
    logic [N-1:0] duty_tgt_q, duty_tgt_d;
    logic [N-1:0] duty_cur_q, duty_cur_d;
    logic [N-1:0] step_act_q, step_act_d;
    logic [N-1:0] sh_period_q, sh_period_d;
    logic [N-1:0] sh_duty_q, sh_duty_d;
    logic [N-1:0] sh_step_q, sh_step_d;
    logic         pending_q, pending_d;
    logic         pwm_q, pwm_d;

    logic [N-1:0] count;
    logic         wrap;
    logic         running;
    logic         accept;
    logic         load;
    logic [N-1:0] diff;
    logic [N-1:0] ramp_val;

    assign running = (state_q != ST_IDLE);

    pwm_period_counter #(.N(N)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (~running | ~enable),
        .en_i    (running),
        .term_i  (period_act_q),
        .count_o (count),
        .wrap_o  (wrap)
    );

    always_comb begin
        state_d      = state_q;
        duty_cur_d   = duty_cur_q;
        sh_period_d  = sh_period_q;
        sh_duty_d    = sh_duty_q;
        sh_step_d    = sh_step_q;

        accept = cfg.cfg_valid & ~pending_q;
        // In IDLE the shadow lands on the cycle after acceptance; while
        // running it waits for a period boundary so a period never changes
        // shape halfway through.
        load   = pending_q & (running ? wrap : 1'b1);

        pending_d    = accept | (pending_q & ~load);
        period_act_d = load ? sh_period_q : period_act_q;
        duty_tgt_d   = load ? sh_duty_q   : duty_tgt_q;
        step_act_d   = load ? sh_step_q   : step_act_q;

        if (accept) begin
            sh_period_d = cfg.cfg_period;
            sh_duty_d   = cfg.cfg_duty;
            sh_step_d   = cfg.cfg_step;
        end

        // Ramp uses the values loaded at this same boundary; the final step
        // snaps to the target so duty_cur never overshoots or wraps.
        diff = (duty_tgt_d >= duty_cur_q) ? (duty_tgt_d - duty_cur_q)
                                          : (duty_cur_q - duty_tgt_d);
        if ((step_act_d == '0) || (diff <= step_act_d)) begin
            ramp_val = duty_tgt_d;
        end else if (duty_tgt_d > duty_cur_q) begin
            ramp_val = duty_cur_q + step_act_d;
        end else begin
            ramp_val = duty_cur_q - step_act_d;
        end

        case (state_q)
            ST_IDLE: begin
                duty_cur_d = '0;
                if (enable) begin
                    state_d = (duty_tgt_d != '0) ? ST_RAMP : ST_RUN;
                end
            end
            ST_RUN, ST_RAMP: begin
                if (wrap) begin
                    duty_cur_d = ramp_val;
                    state_d    = (ramp_val == duty_tgt_d) ? ST_RUN : ST_RAMP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable) begin
            state_d    = ST_IDLE;
            duty_cur_d = '0;
        end

        pwm_d = running & enable & (count < duty_cur_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            period_act_q <= PERIOD_RST;
            duty_tgt_q   <= '0;
            duty_cur_q   <= '0;
            step_act_q   <= '0;
            sh_period_q  <= '0;
            sh_duty_q    <= '0;
            sh_step_q    <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_act_q <= period_act_d;
            duty_tgt_q   <= duty_tgt_d;
            duty_cur_q   <= duty_cur_d;
            step_act_q   <= step_act_d;
            sh_period_q  <= sh_period_d;
            sh_duty_q    <= sh_duty_d;
            sh_step_q    <= sh_step_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
        end
    end

    assign cfg.cfg_ready = ~pending_q;
    assign count_out     = count;
    assign pwm_out       = pwm_q;
    assign period_done   = wrap;
    assign busy          = (state_q == ST_RAMP);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl. Expected per-period records (terminal
// count, PWM high cycles, busy, period length) are queued by the stimulus
// and checked by a monitor as each period completes.
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;

    localparam int N = PWM_W;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] count_out;
    logic         pwm_out;
    logic         period_done;
    logic         busy;

    pwm_ramp_ctrl_if #(.N(N)) cfg_if ();

    pwm_ramp_ctrl #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cfg         (cfg_if),
        .count_out   (count_out),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int hi;
        int busy;
        int len;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int cnt, input int hi, input int b, input int len);
        rec_t r;
        r.cnt  = cnt;
        r.hi   = hi;
        r.busy = b;
        r.len  = len;
        exp_q.push_back(r);
    endtask

    task automatic send(input string tag, input int p, input int d, input int s);
        int k;
        k = 0;
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = N'(p);
        cfg_if.cfg_duty   = N'(d);
        cfg_if.cfg_step   = N'(s);
        while (!cfg_if.cfg_ready && k < 100) begin
            step();
            k++;
        end
        chk({tag, "_ready"}, cfg_if.cfg_ready, 1);
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!period_done && k < 2000) begin
            step();
            k++;
        end
        chk(tag, period_done, 1);
    endtask

    task automatic sync(input string tag);
        wait_done(tag);
        step();
        step();
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (!cfg_if.cfg_ready && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, cfg_if.cfg_ready, 1);
    endtask

    task automatic drain(input string tag, input int limit);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            step();
            k++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // A pwm sample reflects the previous cycle's count, so a period's
    // record closes one cycle after its period_done pulse.
    initial begin : monitor
        int   hi_acc;
        int   len_since;
        int   cap_cnt;
        int   cap_busy;
        int   cap_len;
        int   rec_idx;
        bit   done_prev;
        bit   seen_done;
        bit   cap_ok;
        rec_t e;
        hi_acc    = 0;
        len_since = 0;
        cap_cnt   = 0;
        cap_busy  = 0;
        cap_len   = 0;
        rec_idx   = 0;
        done_prev = 1'b0;
        seen_done = 1'b0;
        cap_ok    = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !enable) begin
                hi_acc    = 0;
                len_since = 0;
                done_prev = 1'b0;
                seen_done = 1'b0;
            end else begin
                hi_acc += int'(pwm_out);
                if (done_prev) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("rec%0d_cnt", rec_idx), cap_cnt, e.cnt);
                        chk($sformatf("rec%0d_hi", rec_idx), hi_acc, e.hi);
                        chk($sformatf("rec%0d_busy", rec_idx), cap_busy, e.busy);
                        if (cap_ok) begin
                            chk($sformatf("rec%0d_len", rec_idx), cap_len, e.len);
                        end
                        rec_idx++;
                    end
                    hi_acc = 0;
                end
                len_since++;
                done_prev = period_done;
                if (period_done) begin
                    cap_cnt   = int'(count_out);
                    cap_busy  = int'(busy);
                    cap_len   = len_since;
                    cap_ok    = seen_done;
                    seen_done = 1'b1;
                    len_since = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        reset             = 1'b1;
        enable            = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_period = '0;
        cfg_if.cfg_duty   = '0;
        cfg_if.cfg_step   = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_count", count_out, 0);
        chk("rst_pwm", pwm_out, 0);
        chk("rst_done", period_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_if.cfg_ready, 1);

        // default 512-cycle period, duty 0
        enable = 1'b1;
        step();
        step();
        chk("def_count1", count_out, 1);
        chk("def_busy", busy, 0);
        push(511, 0, 0, 512);
        push(511, 0, 0, 512);
        drain("drain_default", 1500);
        enable = 1'b0;
        step();
        chk("dis_count", count_out, 0);
        chk("dis_pwm", pwm_out, 0);
        step();

        // config in IDLE, jump to duty 4
        send("cfg_p9d4", 9, 4, 0);
        chk("idle_ready_low", cfg_if.cfg_ready, 0);
        step();
        chk("idle_ready_back", cfg_if.cfg_ready, 1);
        push(9, 0, 1, 10);
        push(9, 4, 0, 10);
        push(9, 4, 0, 10);
        enable = 1'b1;
        drain("drain_jump", 100);

        // ramp 0 -> 8 by 3
        send("cfg_d0", 9, 0, 0);
        wait_ready("ld_d0", n);
        sync("sync_ramp");
        push(9, 0, 0, 10);
        send("cfg_ramp", 9, 8, 3);
        chk("ramp_acc_count", count_out, 2);
        chk("ramp_ready_low", cfg_if.cfg_ready, 0);
        wait_ready("ramp_ld", n);
        chk("ramp_ready_low_cycles", n, 8);
        push(9, 3, 1, 10);
        push(9, 6, 1, 10);
        push(9, 8, 0, 10);
        drain("drain_ramp", 100);

        // two words with cfg_valid held
        sync("sync_two");
        push(9, 8, 0, 10);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = N'(9);
        cfg_if.cfg_duty   = N'(2);
        cfg_if.cfg_step   = N'(0);
        step();
        chk("two_a_pending", cfg_if.cfg_ready, 0);
        cfg_if.cfg_duty = N'(5);
        wait_ready("two_b", n);
        chk("two_b_wait", n, 8);
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("two_b_pending", cfg_if.cfg_ready, 0);
        push(9, 2, 0, 10);
        push(9, 5, 0, 10);
        drain("drain_two", 100);

        // word offered on a boundary cycle waits one period
        wait_done("bnd_done");
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = N'(9);
        cfg_if.cfg_duty   = N'(7);
        cfg_if.cfg_step   = N'(0);
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("bnd_pending", cfg_if.cfg_ready, 0);
        step();
        push(9, 5, 0, 10);
        push(9, 7, 0, 10);
        drain("drain_bnd", 100);

        // period 0
        enable = 1'b0;
        step();
        step();
        send("cfg_p0d1", 0, 1, 0);
        step();
        enable = 1'b1;
        push(0, 0, 1, 1);
        repeat (4) push(0, 1, 0, 1);
        drain("drain_p0", 50);
        chk("p0_pwm_high", pwm_out, 1);
        chk("p0_done", period_done, 1);
        chk("p0_count", count_out, 0);
        send("cfg_p0d0", 0, 0, 0);
        repeat (3) step();
        chk("p0_pwm_low", pwm_out, 0);
        chk("p0_done_low", period_done, 1);

        // enable drop mid-ramp restarts from duty 0
        enable = 1'b0;
        step();
        step();
        send("cfg_r2", 9, 8, 3);
        step();
        enable = 1'b1;
        sync("sync_mid");
        enable = 1'b0;
        step();
        chk("mid_busy", busy, 0);
        chk("mid_pwm", pwm_out, 0);
        chk("mid_count", count_out, 0);
        chk("mid_done", period_done, 0);
        enable = 1'b1;
        push(9, 0, 1, 10);
        push(9, 3, 1, 10);
        drain("drain_restart", 100);

        // reset mid-ramp with a pending word discards it
        send("cfg_discard", 5, 2, 0);
        reset = 1'b1;
        step();
        chk("rr_count", count_out, 0);
        chk("rr_pwm", pwm_out, 0);
        chk("rr_done", period_done, 0);
        chk("rr_busy", busy, 0);
        chk("rr_ready", cfg_if.cfg_ready, 1);
        reset = 1'b0;
        push(511, 0, 0, 512);
        push(511, 0, 0, 512);
        drain("drain_after_reset", 1500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
